serializer_piso_handshake: RTL and testbench
============================================

// Module: serializer_piso_handshake
// PURPOSE
//  Parallel-in/serial-out stage directly upstream of the 4-bit SIPO shift register.
//  Accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first on a
//  1-bit stream, so a left-shifting SIPO on the same clock rebuilds the word unchanged.
//  A one-entry holding register lets back-to-back words stream with no idle bit.
// PARAMETERS
//  WIDTH   4   word width in bits; must be >= 2. Counter width is $clog2(WIDTH).
// PORTS
//  clk           in   1      rising-edge clock; the only clock
//  clear         in   1      reset, synchronous, active-high; overrides every other input
//  load_valid    in   1      upstream has a word on load_data
//  load_data     in   WIDTH  word to serialize
//  load_ready    out  1      block can take a word this cycle
//  shift_en      in   1      advance enable; 0 = freeze the active frame
//  serial_out    out  1      serial bit, MSB first; drives the SIPO serial_in
//  serial_valid  out  1      serial_out carries a frame bit
//  frame_start   out  1      high while the first bit (MSB) of a frame is on serial_out
//  frame_last    out  1      high while the last bit (LSB) of a frame is on serial_out
//  busy          out  1      frame active, or holding register full
// BEHAVIOUR
//  - State: IDLE/SHIFT. Registers: sreg[WIDTH-1:0], cnt, hold_data[WIDTH-1:0], hold_full.
//  - Reset (clk edge with clear=1): state=IDLE, sreg=0, cnt=0, hold_data=0, hold_full=0.
//    Any word offered in that cycle is dropped. load_ready=0 while clear=1.
//  - Accept = load_valid & load_ready. load_ready = !clear & (IDLE | !hold_full).
//  - IDLE: on accept, sreg<=load_data, cnt<=0, ->SHIFT. shift_en is ignored here.
//    First bit is visible in the cycle after the accepting edge (latency 1).
//  - SHIFT, shift_en=1, cnt<WIDTH-1: sreg<=sreg<<1, cnt<=cnt+1.
//  - SHIFT, shift_en=1, cnt==WIDTH-1 (last bit):
//      hold_full            -> sreg<=hold_data, hold_full<=0, cnt<=0, stay SHIFT
//      !hold_full & accept  -> sreg<=load_data (bypass), cnt<=0, stay SHIFT
//      otherwise            -> IDLE, sreg<=0
//  - SHIFT, any other accept -> hold_data<=load_data, hold_full<=1. This includes
//    accepts made while shift_en=0.
//  - shift_en=0 in SHIFT: sreg, cnt and state hold; outputs stay stable.
//  - Outputs are combinational from registers only, with no input-to-output path except
//    load_ready<-clear:
//      serial_valid = SHIFT
//      serial_out   = SHIFT ? sreg[WIDTH-1] : 0
//      frame_start  = SHIFT & cnt==0
//      frame_last   = SHIFT & cnt==WIDTH-1
//      busy         = SHIFT | hold_full
//  - Reset values of outputs: serial_out=0, serial_valid=0, frame_start=0,
//    frame_last=0, busy=0.
//  - Chaining (same clk and clear, shift_en=1): a word accepted at edge E0 appears
//    complete on SIPO parallel_out after edge E0+WIDTH.
//  - Continuous streaming: a new frame_start follows frame_last on the next cycle,
//    with no gap.
//  - clear mid-frame aborts the frame and empties the holding register. A partial word
//    already shifted into the SIPO is its own reset's concern.
// TESTING
//  1. clear 1 cycle, then offer 4'b1011 in IDLE -> serial_out 1,0,1,1 on 4 consecutive
//     cycles; frame_start on cycle 1, frame_last on cycle 4; chained SIPO reads 4'b1011.
//  2. Offer 4'b1100, then 4'b0110 during frame 1 -> 8 contiguous valid bits
//     1,1,0,0,0,1,1,0; load_ready=0 from the hold-fill edge until the last bit of frame 1.
//  3. Hold empty, offer 4'b1001 exactly in the frame_last cycle -> bypass; next cycle
//     frame_start=1 and serial_out=1.
//  4. 4'b1010 with shift_en=0 for 3 cycles after bit 2 -> serial_out frozen at 0 and
//     frame_last stays low; on resume the remaining bits 1,0 follow. Total 7 valid cycles.
//  5. clear during bit 3 of a frame with hold full -> next cycle serial_valid=0,
//     serial_out=0, busy=0, load_ready=1; no stale bits afterwards.
//  6. WIDTH=8 instance, offer 8'hA5 -> serial_out 1,0,1,0,0,1,0,1; frame_last on bit 8.

Source files
------------

// File: rtl/serializer_piso_handshake.sv
// -----------------------------------------------------------------------------
// serializer_piso_handshake
// Parallel-in / serial-out stage feeding a left-shifting SIPO on the same clock.
// Words arrive on a valid/ready handshake. Each word is sent MSB first on a 1-bit
// stream. A one-entry holding register lets back-to-back frames stream with no
// idle bit between them.
//
// Ports
//   clk           rising-edge clock
//   clear         synchronous active-high reset; overrides every other input
//   load_valid    upstream offers load_data this cycle
//   load_data     WIDTH-bit word to serialize
//   load_ready    a word offered this cycle is taken
//   shift_en      advance enable; 0 freezes the active frame
//   serial_out    current serial bit (MSB first), 0 when no frame is active
//   serial_valid  serial_out carries a frame bit
//   frame_start   first bit of a frame is on serial_out
//   frame_last    last bit of a frame is on serial_out
//   busy          frame active or holding register full
// -----------------------------------------------------------------------------
module serializer_piso_handshake #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             frame_last,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] sreg_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] hold_data_r;
    logic             hold_full_r;

    logic             accept_s;

    // Handshake: IDLE always takes a word; SHIFT takes one only into an empty hold slot.
    always_comb begin
        load_ready = 1'b0;
        accept_s   = 1'b0;
        if (clear) begin
            load_ready = 1'b0;
        end else begin
            load_ready = (state_r == IDLE) || !hold_full_r;
        end
        accept_s = load_valid && load_ready;
    end

    // Frame sequencer: shift register, bit counter and holding register.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_r     <= IDLE;
            sreg_r      <= {WIDTH{1'b0}};
            cnt_r       <= CNT_ZERO;
            hold_data_r <= {WIDTH{1'b0}};
            hold_full_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        sreg_r  <= load_data;
                        cnt_r   <= CNT_ZERO;
                        state_r <= SHIFT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    if (shift_en && (cnt_r == CNT_LAST)) begin
                        // Last bit leaves now: chain straight into the next word if one exists.
                        if (hold_full_r) begin
                            sreg_r      <= hold_data_r;
                            hold_full_r <= 1'b0;
                            cnt_r       <= CNT_ZERO;
                        end else if (accept_s) begin
                            sreg_r <= load_data;
                            cnt_r  <= CNT_ZERO;
                        end else begin
                            state_r <= IDLE;
                            sreg_r  <= {WIDTH{1'b0}};
                            cnt_r   <= CNT_ZERO;
                        end
                    end else begin
                        if (shift_en) begin
                            sreg_r <= {sreg_r[WIDTH-2:0], 1'b0};
                            cnt_r  <= cnt_r + CW'(1);
                        end else begin
                            cnt_r <= cnt_r;
                        end
                        // Any accept outside the last-bit slot parks the word, frozen or not.
                        if (accept_s) begin
                            hold_data_r <= load_data;
                            hold_full_r <= 1'b1;
                        end else begin
                            hold_full_r <= hold_full_r;
                        end
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    sreg_r      <= {WIDTH{1'b0}};
                    cnt_r       <= CNT_ZERO;
                    hold_full_r <= 1'b0;
                end
            endcase
        end
    end

    // Stream outputs decoded from registers only, so they never glitch with inputs.
    always_comb begin
        serial_valid = (state_r == SHIFT);
        serial_out   = (state_r == SHIFT) ? sreg_r[WIDTH-1] : 1'b0;
        frame_start  = (state_r == SHIFT) && (cnt_r == CNT_ZERO);
        frame_last   = (state_r == SHIFT) && (cnt_r == CNT_LAST);
        busy         = (state_r == SHIFT) || hold_full_r;
    end

endmodule

// File: tb/tb_serializer_piso_handshake.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for serializer_piso_handshake.
// Expected bits of every offered word are queued when the word is driven and
// compared against the stream as the DUT advances. A WIDTH=8 instance is
// checked directly at the end.
// -----------------------------------------------------------------------------
module tb_serializer_piso_handshake;

    logic       clk;
    logic       clear;
    logic       load_valid;
    logic [3:0] load_data;
    logic       load_ready;
    logic       shift_en;
    logic       serial_out;
    logic       serial_valid;
    logic       frame_start;
    logic       frame_last;
    logic       busy;

    logic       load_valid8;
    logic [7:0] load_data8;
    logic       load_ready8;
    logic       serial_out8;
    logic       serial_valid8;
    logic       frame_start8;
    logic       frame_last8;
    logic       busy8;

    logic [3:0] sipo;

    typedef struct packed {
        logic b;
        logic s;
        logic l;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic seen_valid = 1'b0;

    serializer_piso_handshake #(.WIDTH(4)) dut (
        .clk          (clk),
        .clear        (clear),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_ready   (load_ready),
        .shift_en     (shift_en),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .frame_start  (frame_start),
        .frame_last   (frame_last),
        .busy         (busy)
    );

    serializer_piso_handshake #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .clear        (clear),
        .load_valid   (load_valid8),
        .load_data    (load_data8),
        .load_ready   (load_ready8),
        .shift_en     (1'b1),
        .serial_out   (serial_out8),
        .serial_valid (serial_valid8),
        .frame_start  (frame_start8),
        .frame_last   (frame_last8),
        .busy         (busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream 4-bit SIPO, shifting left every clock.
    always @(posedge clk) sipo <= {sipo[2:0], serial_out};

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) begin
            exp_q.push_back('{b: w[i], s: (i == 3), l: (i == 0)});
        end
    endtask

    // Compare the stream outputs against the head of the scoreboard.
    task automatic check();
        logic has;
        has = (exp_q.size() > 0);
        chk1("serial_valid", serial_valid, has);
        chk1("busy", busy, has);
        if (has) begin
            chk1("serial_out", serial_out, exp_q[0].b);
            chk1("frame_start", frame_start, exp_q[0].s);
            chk1("frame_last", frame_last, exp_q[0].l);
        end else begin
            chk1("idle_serial_out", serial_out, 1'b0);
            chk1("idle_frame_start", frame_start, 1'b0);
            chk1("idle_frame_last", frame_last, 1'b0);
        end
        seen_valid = serial_valid;
    endtask

    // One clock: retire the shown bit if it advanced, flush on clear, then check.
    task automatic cycle();
        logic adv;
        logic clr;
        adv = seen_valid & shift_en;
        clr = clear;
        @(posedge clk);
        if (clr) begin
            exp_q.delete();
        end else if (adv && (exp_q.size() > 0)) begin
            void'(exp_q.pop_front());
        end
        #1;
        check();
    endtask

    task automatic offer(input logic [3:0] w);
        load_valid = 1'b1;
        load_data  = w;
        #1;
        chk1("ready_on_offer", load_ready, 1'b1);
        push_word(w);
        cycle();
        load_valid = 1'b0;
    endtask

    initial begin
        int         vcnt;
        logic [7:0] w8;

        clear       = 1'b1;
        load_valid  = 1'b0;
        load_data   = 4'h0;
        shift_en    = 1'b1;
        load_valid8 = 1'b0;
        load_data8  = 8'h00;

        // Reset
        cycle();
        cycle();
        chk1("ready_in_clear", load_ready, 1'b0);
        chk1("valid8_reset", serial_valid8, 1'b0);
        chk1("busy8_reset", busy8, 1'b0);
        clear = 1'b0;
        #1;
        chk1("ready_after_clear", load_ready, 1'b1);

        // 1: single word 1011, chained SIPO rebuilds it
        offer(4'b1011);
        cycle();
        cycle();
        cycle();
        cycle();
        chkn("sipo_word", 32'(sipo), 32'(4'b1011));

        // 2: two words streamed through the holding register
        offer(4'b1100);
        offer(4'b0110);
        chk1("ready_hold_full_b1", load_ready, 1'b0);
        cycle();
        chk1("ready_hold_full_b2", load_ready, 1'b0);
        cycle();
        chk1("ready_hold_full_last", load_ready, 1'b0);
        cycle();
        chk1("ready_hold_drained", load_ready, 1'b1);
        cycle();
        cycle();
        cycle();

        // 3: bypass offered in the frame_last cycle
        chk1("last_before_bypass", frame_last, 1'b1);
        offer(4'b1001);
        chk1("bypass_start", frame_start, 1'b1);
        chk1("bypass_bit", serial_out, 1'b1);
        cycle();
        cycle();
        cycle();
        cycle();

        // 4: freeze for three cycles after bit 2
        vcnt = 0;
        offer(4'b1010);
        vcnt += int'(serial_valid);
        cycle();
        vcnt += int'(serial_valid);
        shift_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            vcnt += int'(serial_valid);
            chk1("frozen_bit", serial_out, 1'b0);
            chk1("frozen_last", frame_last, 1'b0);
        end
        shift_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            vcnt += int'(serial_valid);
        end
        chkn("valid_cycles", 32'(vcnt), 32'd7);

        // 5: clear during bit 3 with the holding register full
        offer(4'b1101);
        offer(4'b0011);
        cycle();
        clear      = 1'b1;
        load_valid = 1'b1;
        load_data  = 4'b1111;
        #1;
        chk1("ready_during_clear", load_ready, 1'b0);
        cycle();
        clear      = 1'b0;
        load_valid = 1'b0;
        #1;
        chk1("abort_ready", load_ready, 1'b1);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_valid", serial_valid, 1'b0);
        chk1("abort_out", serial_out, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle();
        end

        // 6: WIDTH=8 instance with 8'hA5
        w8          = 8'hA5;
        load_valid8 = 1'b1;
        load_data8  = w8;
        #1;
        chk1("ready8_offer", load_ready8, 1'b1);
        cycle();
        load_valid8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk1("serial_out8", serial_out8, w8[7-i]);
            chk1("serial_valid8", serial_valid8, 1'b1);
            chk1("frame_start8", frame_start8, (i == 0));
            chk1("frame_last8", frame_last8, (i == 7));
            cycle();
        end
        chk1("valid8_done", serial_valid8, 1'b0);
        chk1("busy8_done", busy8, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
